reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader_pkg.sv | 28 ++
 rtl/reg_dump_reader.sv | 136 +++++++++++++
 tb/tb_reg_dump_reader.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared processor package: register-file geometry, dump FSM state encoding
// and the dump word payload used by register-file read clients.
package reg_dump_reader_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned PAIR_W   = IDX_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EMIT_A,
    EMIT_B,
    DONE
  } dump_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } dump_word_t;

  // Register index of the even (odd=0) or odd (odd=1) member of pair k.
  function automatic logic [IDX_W-1:0] pair_reg(input logic [PAIR_W-1:0] k, input logic odd);
    return {k, odd};
  endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Register-file dump reader: reads registers two at a time through ports A/B,
// snapshots each pair and streams it out one word at a time over valid/ready.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned LAST_REG = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  output logic [IDX_W-1:0]  RA,
  output logic [IDX_W-1:0]  RB,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  output logic [DATA_W-1:0] DumpData,
  output logic [IDX_W-1:0]  DumpIdx,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic              Busy,
  output logic              Done
);

  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(LAST_REG / 2);

  dump_state_e       state_q, state_d;
  logic [PAIR_W-1:0] k_q, k_d;
  logic [DATA_W-1:0] buf_a_q, buf_a_d;
  logic [DATA_W-1:0] buf_b_q, buf_b_d;
  dump_word_t        word_q, word_d;
  logic [IDX_W-1:0]  ra_q, ra_d;
  logic [IDX_W-1:0]  rb_q, rb_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next state plus the registered outputs that go with that next state.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    ra_d    = '0;
    rb_d    = '0;
    word_d  = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          k_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        buf_a_d = BusA;
        buf_b_d = BusB;
        state_d = EMIT_A;
      end
      EMIT_A: begin
        if (DumpReady) state_d = EMIT_B;
      end
      EMIT_B: begin
        if (DumpReady) begin
          if (k_q == LAST_PAIR) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + PAIR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything except reset.
    if (Abort && (state_q != IDLE)) begin
      state_d = IDLE;
      k_d     = '0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d inside {READ, EMIT_A, EMIT_B}) begin
      ra_d = pair_reg(k_d, 1'b0);
      rb_d = pair_reg(k_d, 1'b1);
    end
    if (state_d == EMIT_A) begin
      valid_d     = 1'b1;
      word_d.idx  = pair_reg(k_d, 1'b0);
      word_d.data = buf_a_d;
    end else if (state_d == EMIT_B) begin
      valid_d     = 1'b1;
      word_d.idx  = pair_reg(k_d, 1'b1);
      word_d.data = buf_b_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
      word_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
      word_q  <= word_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RA        = ra_q;
  assign RB        = rb_q;
  assign DumpData  = word_q.data;
  assign DumpIdx   = word_q.idx;
  assign DumpValid = valid_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: register-file model, handshake
// scoreboard and a snapshot/ordering reference built from the dump rules.
module tb_reg_dump_reader;
  import reg_dump_reader_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        DumpReady = 1'b0;
  logic [4:0]  RA, RB;
  logic [63:0] BusA, BusB;
  logic [63:0] DumpData;
  logic [4:0]  DumpIdx;
  logic        DumpValid, Busy, Done;

  logic        Start3 = 1'b0;
  logic [4:0]  RA3, RB3;
  logic [63:0] BusA3, BusB3;
  logic [63:0] DumpData3;
  logic [4:0]  DumpIdx3;
  logic        DumpValid3, Busy3, Done3;

  logic [63:0] regs [32];
  logic [63:0] exp_regs [32];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [4:0]  got_idx [$];
  logic [63:0] got_data [$];
  int done_cnt, done_cyc, first_valid_cyc, viol;
  logic        hold_prev;
  logic [4:0]  hold_idx;
  logic [63:0] hold_data;
  logic [4:0]  got3_idx [$];
  logic [63:0] got3_data [$];
  int done3_cnt, done3_cyc;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign BusA  = regs[RA];
  assign BusB  = regs[RB];
  assign BusA3 = regs[RA3];
  assign BusB3 = regs[RB3];

  reg_dump_reader #(.LAST_REG(31)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
    .DumpData(DumpData), .DumpIdx(DumpIdx), .DumpValid(DumpValid),
    .DumpReady(DumpReady), .Busy(Busy), .Done(Done)
  );

  reg_dump_reader #(.LAST_REG(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Start(Start3), .Abort(Abort),
    .RA(RA3), .RB(RB3), .BusA(BusA3), .BusB(BusB3),
    .DumpData(DumpData3), .DumpIdx(DumpIdx3), .DumpValid(DumpValid3),
    .DumpReady(1'b1), .Busy(Busy3), .Done(Done3)
  );

  // Handshake monitor: a word is accepted at the next edge when valid&ready
  // are seen here and neither Reset nor Abort will win that edge.
  always @(negedge Clk) begin
    if (!Reset && !Abort && DumpValid && DumpReady) begin
      got_idx.push_back(DumpIdx);
      got_data.push_back(DumpData);
    end
    if (Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (DumpValid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (hold_prev && (!DumpValid || DumpIdx != hold_idx || DumpData != hold_data)) viol++;
    hold_prev = DumpValid && !DumpReady && !Abort && !Reset;
    hold_idx  = DumpIdx;
    hold_data = DumpData;
    if (!Reset && !Abort && DumpValid3) begin
      got3_idx.push_back(DumpIdx3);
      got3_data.push_back(DumpData3);
    end
    if (Done3) begin
      done3_cnt++;
      done3_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_sb();
    got_idx.delete();
    got_data.delete();
    got3_idx.delete();
    got3_data.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_valid_cyc = -1;
    viol = 0;
    hold_prev = 1'b0;
    done3_cnt = 0;
    done3_cyc = -1;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      regs[i] = 64'h1000 + 64'(i);
      exp_regs[i] = regs[i];
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({RA, RB} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_addr: RA=%0d RB=%0d expected 0 0", RA, RB);
    end
    n_checks++;
    if ({DumpValid, DumpData, DumpIdx, Busy, Done} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h idx=%0d busy=%b done=%b expected all 0",
               DumpValid, DumpData, DumpIdx, Busy, Done);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_full_dump();
    int n;
    preload();
    clear_sb();
    DumpReady = 1'b1;
    Start = 1'b1;
    tick();
    n = cyc;
    Start = 1'b0;
    n_checks++;
    if ({Busy, RA, RB} !== {1'b1, 5'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL full_read0: busy=%b RA=%0d RB=%0d expected 1 0 1", Busy, RA, RB);
    end
    repeat (55) tick();
    n_checks++;
    if (got_idx.size() !== 32) begin
      n_fail++;
      $display("FAIL full_count: %0d words expected 32", got_idx.size());
    end
    for (int i = 0; i < got_idx.size() && i < 32; i++) begin
      n_checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL full_word%0d: idx=%0d data=%h expected %0d %h", i, got_idx[i], got_data[i], i, exp_regs[i]);
      end
    end
    n_checks++;
    if (first_valid_cyc - n !== 1) begin
      n_fail++;
      $display("FAIL full_first_valid: at N+%0d expected N+1", first_valid_cyc - n);
    end
    n_checks++;
    if (done_cnt !== 1 || done_cyc - n !== 48) begin
      n_fail++;
      $display("FAIL full_done: %0d pulses at N+%0d expected 1 at N+48", done_cnt, done_cyc - n);
    end
    n_checks++;
    if (Busy !== 1'b0 || viol !== 0) begin
      n_fail++;
      $display("FAIL full_end: busy=%b stability_violations=%0d expected 0 0", Busy, viol);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit stalled;
    preload();
    clear_sb();
    DumpReady = 1'b1;
    Start = 1'b1;
    tick();
    n = cyc;
    Start = 1'b0;
    stalled = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (!stalled && DumpValid && DumpIdx == 5'd6) begin
        stalled = 1'b1;
        DumpReady = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          n_checks++;
          if ({DumpValid, DumpIdx, DumpData} !== {1'b1, 5'd6, 64'h1006}) begin
            n_fail++;
            $display("FAIL bp_hold%0d: valid=%b idx=%0d data=%h expected 1 6 1006", s, DumpValid, DumpIdx, DumpData);
          end
        end
        DumpReady = 1'b1;
      end
      tick();
    end
    n_checks++;
    if (!stalled || got_idx.size() !== 32) begin
      n_fail++;
      $display("FAIL bp_count: stalled=%0d words=%0d expected 1 32", stalled, got_idx.size());
    end
    for (int i = 0; i < got_idx.size() && i < 32; i++) begin
      n_checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL bp_word%0d: idx=%0d data=%h expected %0d %h", i, got_idx[i], got_data[i], i, exp_regs[i]);
      end
    end
    n_checks++;
    if (done_cnt !== 1 || done_cyc - n !== 53 || viol !== 0) begin
      n_fail++;
      $display("FAIL bp_done: %0d pulses at N+%0d viol=%0d expected 1 at N+53 viol 0", done_cnt, done_cyc - n, viol);
    end
  endtask

  task automatic test_snapshot();
    bit written;
    preload();
    clear_sb();
    DumpReady = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    written = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!written && DumpValid && DumpIdx == 5'd4) begin
        written = 1'b1;
        @(negedge Clk);
        regs[10] = 64'hDEAD;
        regs[4]  = 64'hBEEF;
      end
      tick();
    end
    // Pairs captured after the write (pair index > 2) see the new contents.
    for (int i = 0; i < 32; i++) if (i / 2 > 2) exp_regs[i] = regs[i];
    n_checks++;
    if (!written || got_idx.size() !== 32) begin
      n_fail++;
      $display("FAIL snap_count: written=%0d words=%0d expected 1 32", written, got_idx.size());
    end
    n_checks++;
    if (got_idx.size() == 32 && (got_data[10] !== 64'hDEAD || got_data[4] !== 64'h1004)) begin
      n_fail++;
      $display("FAIL snap_x10_x4: X10=%h X4=%h expected DEAD 1004", got_data[10], got_data[4]);
    end
    for (int i = 0; i < got_idx.size() && i < 32; i++) begin
      n_checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL snap_word%0d: idx=%0d data=%h expected %0d %h", i, got_idx[i], got_data[i], i, exp_regs[i]);
      end
    end
  endtask

  task automatic test_abort();
    bit aborted;
    preload();
    clear_sb();
    DumpReady = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    aborted = 1'b0;
    for (int c = 0; c < 40 && !aborted; c++) begin
      if (DumpValid && DumpIdx == 5'd15) begin
        aborted = 1'b1;
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        n_checks++;
        if ({DumpValid, Busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL abort_next: valid=%b busy=%b expected 0 0", DumpValid, Busy);
        end
      end else begin
        tick();
      end
    end
    repeat (20) tick();
    n_checks++;
    if (!aborted || done_cnt !== 0 || got_idx.size() !== 15 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_tail: aborted=%0d done=%0d words=%0d busy=%b expected 1 0 15 0",
               aborted, done_cnt, got_idx.size(), Busy);
    end
    clear_sb();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (55) tick();
    n_checks++;
    if (got_idx.size() !== 32 || got_idx[0] !== 5'd0 || got_data[0] !== 64'h1000 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL abort_restart: words=%0d first_idx=%0d done=%0d expected 32 0 1",
               got_idx.size(), (got_idx.size() > 0) ? got_idx[0] : 5'd31, done_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    preload();
    clear_sb();
    DumpReady = 1'b1;
    Start = 1'b1;
    repeat (4) tick();
    Reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      n_checks++;
      if ({RA, RB, DumpValid, DumpData, DumpIdx, Busy, Done} !== 82'd0) begin
        n_fail++;
        $display("FAIL rst_mid%0d: RA=%0d RB=%0d valid=%b data=%h idx=%0d busy=%b done=%b expected all 0",
                 r, RA, RB, DumpValid, DumpData, DumpIdx, Busy, Done);
      end
    end
    Reset = 1'b0;
    clear_sb();
    tick();
    n = cyc;
    Start = 1'b0;
    n_checks++;
    if ({Busy, RA, RB} !== {1'b1, 5'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL rst_restart: busy=%b RA=%0d RB=%0d expected 1 0 1", Busy, RA, RB);
    end
    repeat (55) tick();
    n_checks++;
    if (got_idx.size() !== 32 || got_idx[0] !== 5'd0 || done_cnt !== 1 || done_cyc - n !== 48) begin
      n_fail++;
      $display("FAIL rst_dump: words=%0d done=%0d at N+%0d expected 32 1 N+48",
               got_idx.size(), done_cnt, done_cyc - n);
    end
  endtask

  task automatic test_last_reg3();
    int n;
    preload();
    clear_sb();
    Start3 = 1'b1;
    tick();
    n = cyc;
    repeat (4) tick();
    Start3 = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (got3_idx.size() !== 4) begin
      n_fail++;
      $display("FAIL lr3_count: %0d words expected 4", got3_idx.size());
    end
    for (int i = 0; i < got3_idx.size() && i < 4; i++) begin
      n_checks++;
      if (got3_idx[i] !== 5'(i) || got3_data[i] !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL lr3_word%0d: idx=%0d data=%h expected %0d %h", i, got3_idx[i], got3_data[i], i, exp_regs[i]);
      end
    end
    n_checks++;
    if (done3_cnt !== 1 || done3_cyc - n !== 6 || Busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL lr3_done: %0d pulses at N+%0d busy=%b expected 1 at N+6 busy 0", done3_cnt, done3_cyc - n, Busy3);
    end
  endtask

  task automatic test_random();
    int n, stalls;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] = {$urandom, $urandom};
        exp_regs[i] = regs[i];
      end
      clear_sb();
      DumpReady = 1'b1;
      Start = 1'b1;
      tick();
      n = cyc;
      Start = 1'b0;
      stalls = 0;
      for (int c = 0; c < 400 && done_cnt == 0; c++) begin
        DumpReady = ($urandom_range(0, 3) != 0);
        if (DumpValid && !DumpReady) stalls++;
        tick();
      end
      DumpReady = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (got_idx.size() !== 32 || viol !== 0) begin
        n_fail++;
        $display("FAIL rnd%0d_count: words=%0d viol=%0d expected 32 0", it, got_idx.size(), viol);
      end
      for (int i = 0; i < got_idx.size() && i < 32; i++) begin
        n_checks++;
        if (got_idx[i] !== 5'(i) || got_data[i] !== exp_regs[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_word%0d: idx=%0d data=%h expected %0d %h", it, i, got_idx[i], got_data[i], i, exp_regs[i]);
        end
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc - n !== 48 + stalls) begin
        n_fail++;
        $display("FAIL rnd%0d_done: %0d pulses at N+%0d expected 1 at N+%0d", it, done_cnt, done_cyc - n, 48 + stalls);
      end
    end
  endtask

  initial begin
    preload();
    clear_sb();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_snapshot();
    test_abort();
    test_reset_mid_read();
    test_last_reg3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
